// File: rtl/reflector_cfg_loader.sv
// Byte-serial loader for the reflector wiring table: collects 26 letters, validates
// range / no fixed points / involution, then commits the packed table with a set pulse.
`timescale 1ns/1ps
module reflector_cfg_loader #(
   parameter int N_LET  = 26,
   parameter int CHAR_W = 8,
   parameter int BASE   = 65
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      cfg_valid,
   input  logic [CHAR_W-1:0]         cfg_data,
   output logic                      cfg_ready,
   output logic [N_LET*CHAR_W-1:0]   idx_out,
   output logic                      set_out,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [1:0]                err_code
);

   localparam int                IDX_W = $clog2(N_LET);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_LET - 1);
   localparam logic [CHAR_W-1:0] LO    = CHAR_W'(BASE);
   localparam logic [CHAR_W-1:0] HI    = CHAR_W'(BASE + N_LET - 1);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, ERR} state_t;

   state_t             state, state_next;
   logic [IDX_W-1:0]   cnt, j, t;
   logic [CHAR_W-1:0]  shadow [N_LET];

   logic       handshake, byte_ok, fixed_pt, not_invol;
   logic       restart, store, step, commit, set_err;
   logic [1:0] code_next;

   assign cfg_ready = (state == LOAD) && !start;
   assign busy      = (state == LOAD) || (state == CHECK) || (state == COMMIT);
   assign handshake = cfg_valid && cfg_ready;
   assign byte_ok   = (cfg_data >= LO) && (cfg_data <= HI);

   // Every stored byte passed the range check, so t always indexes a real entry.
   assign t         = IDX_W'(shadow[j] - LO);
   assign fixed_pt  = (t == j);
   assign not_invol = (shadow[t] != (LO + CHAR_W'(j)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can leave it unassigned
      // and infer a latch.
      state_next = state;
      restart    = 1'b0;
      store      = 1'b0;
      step       = 1'b0;
      commit     = 1'b0;
      set_err    = 1'b0;
      code_next  = 2'd0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
               restart    = 1'b1;
            end
         end
         LOAD: begin
            if (start) begin
               state_next = LOAD;
               restart    = 1'b1;
            end else if (handshake) begin
               if (!byte_ok) begin
                  state_next = ERR;
                  set_err    = 1'b1;
                  code_next  = 2'd1;
               end else begin
                  store = 1'b1;
                  if (cnt == LAST) state_next = CHECK;
               end
            end
         end
         CHECK: begin
            if (start) begin
               state_next = LOAD;
               restart    = 1'b1;
            end else if (fixed_pt) begin
               state_next = ERR;
               set_err    = 1'b1;
               code_next  = 2'd2;
            end else if (not_invol) begin
               state_next = ERR;
               set_err    = 1'b1;
               code_next  = 2'd3;
            end else if (j == LAST) begin
               state_next = COMMIT;
               commit     = 1'b1;
            end else begin
               step = 1'b1;
            end
         end
         COMMIT: state_next = IDLE;
         ERR: begin
            if (start) begin
               state_next = LOAD;
               restart    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // set_out/done/idx_out are registered on the CHECK->COMMIT edge, so the pulse
   // occupies exactly the COMMIT cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         j        <= '0;
         idx_out  <= '0;
         set_out  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'd0;
         // NOTE: the shadow table is cleared on reset so a partial load never
         // survives it; it is small enough to live in flops.
         for (int k = 0; k < N_LET; k++) shadow[k] <= '0;
      end else begin
         set_out <= commit;
         done    <= commit;
         if (restart) begin
            cnt      <= '0;
            j        <= '0;
            err      <= 1'b0;
            err_code <= 2'd0;
         end
         if (store) begin
            shadow[cnt] <= cfg_data;
            if (cnt != LAST) cnt <= cnt + 1'b1;
         end
         if (step) j <= j + 1'b1;
         if (set_err) begin
            err      <= 1'b1;
            err_code <= code_next;
         end
         if (commit) begin
            for (int k = 0; k < N_LET; k++)
               idx_out[(N_LET-1-k)*CHAR_W +: CHAR_W] <= shadow[k];
         end
      end
   end

endmodule

// File: tb/tb_reflector_cfg_loader.sv
// Self-checking bench for reflector_cfg_loader: a transaction-level model predicts
// every output each cycle, and literal checks pin the model on the directed tests.
`timescale 1ns/1ps
module tb_reflector_cfg_loader;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic         cfg_valid;
   logic [7:0]   cfg_data;
   logic         cfg_ready;
   logic [207:0] idx_out;
   logic         set_out;
   logic         busy;
   logic         done;
   logic         err;
   logic [1:0]   err_code;

   reflector_cfg_loader dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .idx_out   (idx_out),
      .set_out   (set_out),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_set    = 0;
   int set_cyc  = -1;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [207:0] act, input logic [207:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef enum {PH_IDLE, PH_LOAD, PH_CHECK, PH_COMMIT, PH_ERR} phase_t;
   phase_t       m_phase;
   logic [7:0]   q[$];
   logic [207:0] m_idx, pend_idx;
   bit           m_err, pend_commit;
   logic [1:0]   m_code, pend_code;
   int           pend_edge;
   int           accept_cyc;

   // Lowest entry violating the reflector rules, or -1 for a valid table.
   function automatic int first_fault(output logic [1:0] code);
      code = 2'd0;
      for (int jj = 0; jj < 26; jj++) begin
         int tt;
         tt = int'(q[jj]) - 65;
         if (tt == jj) begin code = 2'd2; return jj; end
         if (int'(q[tt]) != 65 + jj) begin code = 2'd3; return jj; end
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; q.delete(); m_idx = '0; m_err = 1'b0; m_code = 2'd0; pend_edge = -1;
   endtask

   task automatic model_step();
      int         jf;
      logic [1:0] c;
      if (!reset_n) return;
      if (m_phase == PH_COMMIT) begin m_phase = PH_IDLE; return; end
      if (start) begin
         m_phase = PH_LOAD; q.delete(); m_err = 1'b0; m_code = 2'd0; pend_edge = -1;
         return;
      end
      if (pend_edge == cyc) begin
         pend_edge = -1;
         if (pend_commit) begin m_idx = pend_idx; m_phase = PH_COMMIT; end
         else begin m_err = 1'b1; m_code = pend_code; m_phase = PH_ERR; end
         return;
      end
      if (m_phase == PH_LOAD && cfg_valid) begin
         if (cfg_data < 8'd65 || cfg_data > 8'd90) begin
            m_err = 1'b1; m_code = 2'd1; m_phase = PH_ERR;
         end else begin
            q.push_back(cfg_data);
            if (q.size() == 26) begin
               accept_cyc = cyc;
               m_phase    = PH_CHECK;
               jf = first_fault(c);
               if (jf < 0) begin
                  pend_commit = 1'b1;
                  pend_edge   = cyc + 26;
                  for (int k = 0; k < 26; k++) pend_idx[(25-k)*8 +: 8] = q[k];
               end else begin
                  pend_commit = 1'b0;
                  pend_code   = c;
                  pend_edge   = cyc + 1 + jf;
               end
            end
         end
      end
   endtask

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (set_out) begin n_set++; set_cyc = cyc; end
      if (chk_en) begin
         check("cfg_ready", 208'(cfg_ready), 208'(m_phase == PH_LOAD && !start));
         check("busy",      208'(busy), 208'(m_phase == PH_LOAD || m_phase == PH_CHECK || m_phase == PH_COMMIT));
         check("set_out",   208'(set_out), 208'(m_phase == PH_COMMIT));
         check("done",      208'(done), 208'(m_phase == PH_COMMIT));
         check("err",       208'(err), 208'(m_err));
         check("err_code",  208'(err_code), 208'(m_code));
         check("idx_out",   idx_out, m_idx);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         if (gaps) begin
            cfg_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
         cfg_valid = 1'b1;
         cfg_data  = s[i];
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   string ukw_b = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   string ident = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
   string swp   = "RYUHQSLDPXNGOKMIEBFZCWVJAT";
   int    s0;

   initial begin
      reset_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
      model_reset();
      repeat (3) tick();
      #2 reset_n = 1'b1;
      chk_en = 1'b1;
      tick();
      check("reset idx_out", idx_out, 208'd0);
      check("reset busy", 208'(busy), 208'd0);

      // T1: valid UKW-B table
      s0 = n_set;
      do_start();
      send(ukw_b, 1'b0);
      repeat (30) tick();
      check("T1 set pulses", 208'(n_set - s0), 208'd1);
      check("T1 latency", 208'(set_cyc - accept_cyc), 208'd26);
      check("T1 entry A", 208'(idx_out[207:200]), 208'h59);
      check("T1 entry Z", 208'(idx_out[7:0]), 208'h54);
      check("T1 err", 208'(err), 208'd0);

      // T2: lowercase byte at position 5
      s0 = n_set;
      do_start();
      send("YRUHQa", 1'b0);
      cfg_valid = 1'b1;
      check("T2 err", 208'(err), 208'd1);
      check("T2 err_code", 208'(err_code), 208'd1);
      check("T2 cfg_ready", 208'(cfg_ready), 208'd0);
      repeat (5) tick();
      cfg_valid = 1'b0;
      check("T2 idx kept", 208'(idx_out[207:200]), 208'h59);

      // T3: identity table -> fixed point at j=0
      do_start();
      send(ident, 1'b0);
      repeat (5) tick();
      check("T3 err_code", 208'(err_code), 208'd2);

      // T4: first two entries swapped -> not an involution at j=0
      do_start();
      send(swp, 1'b0);
      repeat (5) tick();
      check("T4 err_code", 208'(err_code), 208'd3);
      check("T2-T4 set pulses", 208'(n_set - s0), 208'd0);

      // T5: aborted partial load, then UKW-B with gaps
      s0 = n_set;
      do_start();
      send(ident.substr(0, 9), 1'b0);
      do_start();
      send(ukw_b, 1'b1);
      repeat (30) tick();
      check("T5 set pulses", 208'(n_set - s0), 208'd1);
      check("T5 entry A", 208'(idx_out[207:200]), 208'h59);

      // T6: async reset in the middle of CHECK
      s0 = n_set;
      do_start();
      send(swp.substr(0, 0), 1'b0);
      do_start();
      send(ukw_b, 1'b0);
      repeat (10) tick();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("T6 async idx_out", idx_out, 208'd0);
      check("T6 async busy", 208'(busy), 208'd0);
      check("T6 async err", 208'(err), 208'd0);
      repeat (3) tick();
      #2 reset_n = 1'b1;
      repeat (30) tick();
      check("T6 set pulses", 208'(n_set - s0), 208'd0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
